disp_value_counter: RTL and testbench

Upstream source for `DisplayController`. It produces the 5-bit `DispVal` (0..MAX_VAL) that the seven-segment driver renders. Two raw push-buttons are synchronised and debounced, and each press steps the value up or down with wrap-around. An optional auto-increment mode steps the value once per programmable tick period.

---
 rtl/disp_value_counter.sv | 139 +++++++++++++
 tb/tb_disp_value_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_value_counter.sv
// Button/auto-driven 0..MAX_VAL value source for the seven-segment display.
// Optional auto-increment is built only when DISP_AUTO_EN is defined.
module disp_value_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 100000000,
    parameter int MAX_VAL         = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       autoEn,
    output logic [4:0] DispVal,
    output logic       wrapPulse
);

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]      VAL_MAX = 5'(MAX_VAL);

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       tick;

    assign btn_raw = {btnDown, btnUp};

    // Index 0 is the up button, index 1 the down button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            s1_reg;
            logic            s2_reg;
            logic            db_reg;
            logic            db_prev_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    press_reg   <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    s1_reg      <= btn_raw[gi];
                    s2_reg      <= s1_reg;
                    db_prev_reg <= db_reg;
                    press_reg   <= db_reg & ~db_prev_reg;
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

`ifdef DISP_AUTO_EN
    localparam int              TC_W    = $clog2(TICK_CYCLES);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_CYCLES - 1);

    logic            auto_en_reg;
    logic [TC_W-1:0] tcnt_reg;

    // autoEn is captured once so the first tick lands TICK_CYCLES edges after it is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_en_reg <= 1'b0;
            tcnt_reg    <= '0;
        end else begin
            auto_en_reg <= autoEn;
            if (!auto_en_reg || tick) begin
                tcnt_reg <= '0;
            end else begin
                tcnt_reg <= tcnt_reg + TC_W'(1);
            end
        end
    end

    assign tick = (tcnt_reg == TC_LAST);
`else
    logic unused_auto_en;

    assign unused_auto_en = autoEn;
    assign tick           = 1'b0;
`endif

    logic [4:0] val_reg;
    logic [4:0] val_next;
    logic       wrap_reg;
    logic       wrap_next;
    logic       inc_req;
    logic       dec_req;

    // Simultaneous presses cancel each other and swallow any tick.
    assign inc_req = (press[0] & ~press[1]) | (~press[0] & ~press[1] & tick);
    assign dec_req = press[1] & ~press[0];

    always_comb begin
        val_next  = val_reg;
        wrap_next = 1'b0;
        if (inc_req) begin
            if (val_reg == VAL_MAX) begin
                val_next  = 5'd0;
                wrap_next = 1'b1;
            end else begin
                val_next = val_reg + 5'd1;
            end
        end else if (dec_req) begin
            if (val_reg == 5'd0) begin
                val_next  = VAL_MAX;
                wrap_next = 1'b1;
            end else begin
                val_next = val_reg - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_reg  <= 5'd0;
            wrap_reg <= 1'b0;
        end else begin
            val_reg  <= val_next;
            wrap_reg <= wrap_next;
        end
    end

    assign DispVal   = val_reg;
    assign wrapPulse = wrap_reg;

endmodule

// File: tb/tb_disp_value_counter.sv
// Scoreboard bench for disp_value_counter: stimulus queues expected value changes,
// a negedge monitor compares every observed change of DispVal/wrapPulse.
module tb_disp_value_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnUp = 1'b0;
    logic       btnDown = 1'b0;
    logic       autoEn = 1'b0;
    logic [4:0] DispVal;
    logic       wrapPulse;

    disp_value_counter #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8),
        .MAX_VAL        (19)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btnUp    (btnUp),
        .btnDown  (btnDown),
        .autoEn   (autoEn),
        .DispVal  (DispVal),
        .wrapPulse(wrapPulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int wrap;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    int   prev_val = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input int v, input int w, input int c);
        exp_t e;
        e.val  = v;
        e.wrap = w;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One button action; expected change (if any) lands 7 edges after first sampling.
    task automatic press(input bit up, input bit dn, input bit expect_change, input int v, input int w);
        int e0;
        btnUp   = up;
        btnDown = dn;
        e0      = cyc + 1;
        if (expect_change) push(v, w, e0 + 7);
        wait_cycles(12);
        btnUp   = 1'b0;
        btnDown = 1'b0;
        wait_cycles(10);
    endtask

    // Monitor: every observed change is matched against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (int'(DispVal) != prev_val || wrapPulse) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_change: got val=%0d wrap=%0b at cycle %0d, want no change",
                                 DispVal, wrapPulse, cyc);
                    end else begin
                        e = q.pop_front();
                        $display("txn cycle %0d: val=%0d wrap=%0b (want val=%0d wrap=%0d cycle=%0d)",
                                 cyc, DispVal, wrapPulse, e.val, e.wrap, e.cyc);
                        check("value", int'(DispVal), e.val);
                        check("wrap", int'(wrapPulse), e.wrap);
                        check("latency", cyc, e.cyc);
                    end
                end
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    check("timeout_val", -1, e.val);
                end
                prev_val = int'(DispVal);
            end
        end
    end

    initial begin
        int a0;
        wait_cycles(2);
        rst = 1'b0;
        check("reset_val", int'(DispVal), 0);
        check("reset_wrap", int'(wrapPulse), 0);
        prev_val = 0;
        mon_on   = 1'b1;
        wait_cycles(3);

        // Clean presses
        press(1, 0, 1, 1, 0);
        press(1, 0, 1, 2, 0);

        // Bounce: 3 high / 1 low five times, then held
        for (int i = 0; i < 5; i++) begin
            btnUp = 1'b1;
            wait_cycles(3);
            btnUp = 1'b0;
            wait_cycles(1);
        end
        press(1, 0, 1, 3, 0);

        press(1, 0, 1, 4, 0);
        press(1, 0, 1, 5, 0);
        // Simultaneous presses at 5: nothing
        press(1, 1, 0, 0, 0);
        press(1, 0, 1, 6, 0);
        press(1, 0, 1, 7, 0);

        // Reset during a debounce at value 7
        btnUp = 1'b1;
        wait_cycles(2);
        push(0, 0, cyc + 1);
        rst   = 1'b1;
        btnUp = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(15);

        // Wrap both directions
        press(0, 1, 1, 19, 1);
        press(1, 0, 1, 0, 1);

        // Button held through reset counts as one press
        btnUp = 1'b1;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        push(1, 0, cyc + 1 + 7);
        wait_cycles(12);
        btnUp = 1'b0;
        wait_cycles(10);

`ifdef DISP_AUTO_EN
        press(0, 1, 1, 0, 0);
        press(0, 1, 1, 19, 1);
        press(0, 1, 1, 18, 0);
        autoEn = 1'b1;
        a0     = cyc + 1;
        push(19, 0, a0 + 8);
        push(0, 1, a0 + 16);
        push(1, 0, a0 + 24);
        push(2, 0, a0 + 32);
        push(3, 0, a0 + 40);
        push(4, 0, a0 + 48);
        push(5, 0, a0 + 56);
        // Up press whose pulse coincides with the tick at a0+48
        wait_until(a0 + 40);
        btnUp = 1'b1;
        wait_until(a0 + 50);
        btnUp = 1'b0;
        wait_until(a0 + 56);
        autoEn = 1'b0;
        wait_cycles(20);
`else
        autoEn = 1'b1;
        wait_cycles(100);
        autoEn = 1'b0;
        check("auto_ignored", int'(DispVal), 1);
`endif

        wait_cycles(10);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("missing_change", -1, e.val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
